lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit between the datapath memory stage and the data memory model.
- Takes one load or store request at a time: byte, half or word, signed or unsigned.
- Checks alignment, generates the word-aligned address, the byte-lane write mask and replicated write data, and extracts plus sign/zero-extends load data.
- Holds the request for a configurable memory latency, then returns a single-cycle response.

Parameters:
- LAT, 1, memory access cycles per request (legal range 1..15).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present from the datapath M stage.
- req_ready  output  1  LSU can accept a request.
- req_wen  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  input  1  1 = zero-extend the load result.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal-size request; valid with resp_valid.
- mem_addr  output  32  word address, {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_wmask  output  8  byte mask; bits [7:4] always 0.
- mem_wen  output  1  memory write strobe.
- mem_ren  output  1  memory read enable.
- mem_rdata  input  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; the counter and all latched request fields go to 0.
  - resp_valid, resp_err, resp_rdata, mem_wen, mem_ren, mem_wmask, mem_addr and mem_wdata all read 0.
  - req_ready is 1, but no request is accepted while rst is low.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - A request is accepted on an edge where req_valid = 1.
  - The request is latched (addr, wdata, size, wen, unsigned).
- Alignment check at accept:
  - Error if size == 3, if size == 1 and addr[0] = 1, or if size == 2 and addr[1:0] != 0.
  - Error: go to RESP with resp_err = 1. No mem_wen or mem_ren is ever asserted.
  - OK: go to BUSY with cnt = LAT-1.
- BUSY:
  - req_ready = 0; mem_addr comes from the latched address.
  - Load: mem_ren = 1 for the whole of BUSY.
  - Store: mem_wen = 1 only in the first BUSY cycle (cnt == LAT-1), so exactly one write per store.
  - cnt decrements each edge.
  - On the edge where cnt == 0: the load result is captured from mem_rdata and the state goes to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; req_ready = 0.
  - The next edge always goes to IDLE. There is no back-to-back accept in RESP.
- Latency: accept at edge k gives resp_valid in the cycle following edge k+LAT, i.e. LAT+1 cycles from accept.
  - Misaligned requests respond in the cycle following edge k (1 cycle).
- Store lanes (off = addr[1:0]):
  - Byte: wmask = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - Half: wmask = 4'b0011<<off, wdata = {2{wdata[15:0]}}.
  - Word: wmask = 4'hF, wdata = wdata.
  - mem_wmask and mem_wdata are 0 outside BUSY stores.
- Load extract:
  - Byte: (mem_rdata >> 8*off)[7:0].
  - Half: (mem_rdata >> 8*off)[15:0].
  - Word: as-is.
  - Sign-extend from the MSB unless req_unsigned = 1, then zero-extend.
- resp_rdata holds the captured value only during RESP; it is 0 otherwise.
- Requests presented while not in IDLE are ignored; the datapath must hold them until accepted.
- Reset mid-BUSY: the access is abandoned immediately and no response is issued. Any write strobe already issued is not undone.

Test Plan:
- Load word, LAT=1: addr 0x80000004, mem_rdata 0xDEADBEEF -> mem_addr 0x80000004, mem_ren high 1 cycle, resp_valid 2 cycles after accept, resp_rdata 0xDEADBEEF, resp_err 0.
- Signed/unsigned byte load: addr 0x80000003, mem_rdata 0x85001122, unsigned 0 -> 0xFFFFFF85; unsigned 1 -> 0x00000085. Half at offset 2, signed -> 0xFFFF8500.
- Store byte/half: byte 0xAB at 0x80000001 -> wmask 0x02, wdata 0xABABABAB, mem_wen exactly 1 cycle. Half 0x1234 at offset 2 -> wmask 0x0C, wdata 0x12341234.
- Misaligned: half at 0x80000001, word at 0x80000002, size 3 -> resp_err 1 one cycle after accept, resp_rdata 0, mem_wen and mem_ren never high.
- LAT=4 store then load back-to-back with req_valid held high:
  - mem_wen high only in the first BUSY cycle.
  - req_ready low for 5 cycles per request.
  - Second request accepted the cycle after the RESP cycle.
- Reset asserted (rst=0) in the 2nd BUSY cycle with LAT=4 -> all outputs 0 asynchronously, no resp_valid. After release, a new load completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// ============================================================================
// lsu_ctrl : single-outstanding load/store unit with lane steering, load
//            extension and a fixed, parameterised memory latency.
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_CNT_INIT = 4'(LAT - 1);
  localparam logic [1:0] c_SIZE_B   = 2'd0;
  localparam logic [1:0] c_SIZE_H   = 2'd1;
  localparam logic [1:0] c_SIZE_W   = 2'd2;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_wen;
  logic        r_uns;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_misalign;
  logic        w_accept;
  logic        w_busy;
  logic        w_busy_st;
  logic [3:0]  w_lane_mask;
  logic [31:0] w_lane_data;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;

  // Alignment is judged on the live request so an error can skip BUSY entirely.
  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      c_SIZE_B: w_misalign = 1'b0;
      c_SIZE_H: w_misalign = req_addr[0];
      c_SIZE_W: w_misalign = (req_addr[1:0] != 2'b00);
      default:  w_misalign = 1'b1;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_misalign ? S_RESP : S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_lane_mask = 4'hF;
    w_lane_data = r_wdata;
    case (r_size)
      c_SIZE_B: begin
        w_lane_mask = 4'b0001 << r_addr[1:0];
        w_lane_data = {4{r_wdata[7:0]}};
      end
      c_SIZE_H: begin
        w_lane_mask = 4'b0011 << r_addr[1:0];
        w_lane_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_lane_mask = 4'hF;
        w_lane_data = r_wdata;
      end
    endcase
  end

  assign w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_ext = mem_rdata;
    case (r_size)
      c_SIZE_B: w_load_ext = r_uns ? {24'h000000, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      c_SIZE_H: w_load_ext = r_uns ? {16'h0000, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default:  w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'd0;
      r_wen   <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_wen   <= req_wen;
        r_uns   <= req_unsigned;
        r_err   <= w_misalign;
        r_cnt   <= c_CNT_INIT;
        r_rdata <= 32'd0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
        // Data is sampled on the final BUSY edge, after the full latency.
        if ((r_cnt == 4'd0) && !r_wen) begin
          r_rdata <= w_load_ext;
        end
      end
    end
  end

  assign w_busy    = (r_state == S_BUSY);
  assign w_busy_st = w_busy && r_wen;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = (r_state == S_RESP) && r_err;
  assign resp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;

  assign mem_addr  = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_ren   = w_busy && !r_wen;
  // Only the first BUSY cycle writes, so each store lands exactly once.
  assign mem_wen   = w_busy_st && (r_cnt == c_CNT_INIT);
  assign mem_wmask = w_busy_st ? {4'b0000, w_lane_mask} : 8'h00;
  assign mem_wdata = w_busy_st ? w_lane_data : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// tb_lsu_ctrl : scoreboard bench for lsu_ctrl at LAT=1 and LAT=4.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid1, req_valid4;
  logic        req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        req_ready1, resp_valid1, resp_err1, mem_wen1, mem_ren1;
  logic [31:0] resp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [7:0]  mem_wmask1;
  logic        req_ready4, resp_valid4, resp_err4, mem_wen4, mem_ren4;
  logic [31:0] resp_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic [7:0]  mem_wmask4;

  logic [31:0] mem4 [16];

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [32:0] q1 [$];
  logic [32:0] q4 [$];
  logic [32:0] e1, e4;

  logic        cur;
  logic        t_ready, t_rv, t_wen, t_ren;
  logic [31:0] t_addr, t_wdata;
  logic [7:0]  t_wmask;

  logic [11:0] rdy_v, wen_v, ren_v, rv_v;

  always #5 clk = ~clk;

  lsu_ctrl #(.LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1),
    .mem_wen(mem_wen1), .mem_ren(mem_ren1), .mem_rdata(mem_rdata1)
  );

  lsu_ctrl #(.LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid4), .resp_rdata(resp_rdata4), .resp_err(resp_err4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_wmask(mem_wmask4),
    .mem_wen(mem_wen4), .mem_ren(mem_ren4), .mem_rdata(mem_rdata4)
  );

  // Small byte-masked memory behind the LAT=4 instance.
  assign mem_rdata4 = mem4[mem_addr4[5:2]];
  always @(posedge clk) begin
    if (mem_wen4) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask4[b]) mem4[mem_addr4[5:2]][8*b +: 8] <= mem_wdata4[8*b +: 8];
      end
    end
  end

  assign t_ready = cur ? req_ready4  : req_ready1;
  assign t_rv    = cur ? resp_valid4 : resp_valid1;
  assign t_wen   = cur ? mem_wen4    : mem_wen1;
  assign t_ren   = cur ? mem_ren4    : mem_ren1;
  assign t_addr  = cur ? mem_addr4   : mem_addr1;
  assign t_wdata = cur ? mem_wdata4  : mem_wdata1;
  assign t_wmask = cur ? mem_wmask4  : mem_wmask1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitors: pop the expected {err, rdata} whenever a response appears.
  always @(negedge clk) begin
    if (resp_valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("resp1_unexpected", {31'b0, resp_valid1}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("resp1_rdata", resp_rdata1, e1[31:0]);
        chk("resp1_err", {31'b0, resp_err1}, {31'b0, e1[32]});
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid4 === 1'b1) begin
      if (q4.size() == 0) begin
        chk("resp4_unexpected", {31'b0, resp_valid4}, 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk("resp4_rdata", resp_rdata4, e4[31:0]);
        chk("resp4_err", {31'b0, resp_err4}, {31'b0, e4[32]});
      end
    end
  end

  task automatic do_req(input logic sel, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [7:0] exp_mask, input logic [31:0] exp_mdata);
    int lat, cyc, wc, rc;
    lat = sel ? 4 : 1;
    cur = sel;
    @(negedge clk);
    chk("ready_idle", {31'b0, t_ready}, 32'd1);
    req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    if (sel) begin
      req_valid4 = 1'b1;
      q4.push_back({exp_err, exp_rdata});
    end else begin
      req_valid1 = 1'b1;
      q1.push_back({exp_err, exp_rdata});
    end
    @(negedge clk);
    req_valid1 = 1'b0;
    req_valid4 = 1'b0;
    wc = 0; rc = 0; cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc = i;
      if (t_wen) begin
        wc++;
        chk("wmask", {24'b0, t_wmask}, {24'b0, exp_mask});
        chk("wdata", t_wdata, exp_mdata);
        chk("waddr", t_addr, {addr[31:2], 2'b00});
      end
      if (t_ren) begin
        rc++;
        if (rc == 1) chk("raddr", t_addr, {addr[31:2], 2'b00});
      end
      if (t_rv) break;
      @(negedge clk);
    end
    chk("latency", 32'(cyc), exp_err ? 32'd1 : 32'(lat + 1));
    chk("wen_cycles", 32'(wc), (wen && !exp_err) ? 32'd1 : 32'd0);
    chk("ren_cycles", 32'(rc), (!wen && !exp_err) ? 32'(lat) : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    cur = 1'b0;
    req_valid1 = 1'b0; req_valid4 = 1'b0;
    req_wen = 1'b0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_size = 2'd0;
    mem_rdata1 = 32'd0;
    for (int i = 0; i < 16; i++) mem4[i] = 32'd0;
    mem4[4] = 32'h11223344;
    mem4[5] = 32'h55667788;

    repeat (2) @(negedge clk);
    chk("reset_ready", {31'b0, req_ready1}, 32'd1);
    chk("reset_ctrl", {20'b0, resp_valid1, resp_err1, mem_wen1, mem_ren1, mem_wmask1}, 32'd0);
    chk("reset_rdata", resp_rdata1, 32'd0);
    chk("reset_addr", mem_addr1, 32'd0);
    chk("reset_wdata", mem_wdata1, 32'd0);
    rst = 1'b1;

    // LAT=1 loads
    mem_rdata1 = 32'hDEADBEEF;
    do_req(1'b0, 1'b0, 32'h80000004, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 8'h00, 32'h0);
    mem_rdata1 = 32'h85001122;
    do_req(1'b0, 1'b0, 32'h80000003, 32'h0, 2'd0, 1'b0, 32'hFFFFFF85, 1'b0, 8'h00, 32'h0);
    do_req(1'b0, 1'b0, 32'h80000003, 32'h0, 2'd0, 1'b1, 32'h00000085, 1'b0, 8'h00, 32'h0);
    do_req(1'b0, 1'b0, 32'h80000002, 32'h0, 2'd1, 1'b0, 32'hFFFF8500, 1'b0, 8'h00, 32'h0);
    do_req(1'b0, 1'b0, 32'h80000000, 32'h0, 2'd1, 1'b1, 32'h00001122, 1'b0, 8'h00, 32'h0);
    do_req(1'b0, 1'b0, 32'h80000001, 32'h0, 2'd0, 1'b0, 32'h00000011, 1'b0, 8'h00, 32'h0);

    // LAT=1 stores
    do_req(1'b0, 1'b1, 32'h80000001, 32'h123456AB, 2'd0, 1'b0, 32'h0, 1'b0, 8'h02, 32'hABABABAB);
    do_req(1'b0, 1'b1, 32'h80000002, 32'hFFFF1234, 2'd1, 1'b0, 32'h0, 1'b0, 8'h0C, 32'h12341234);
    do_req(1'b0, 1'b1, 32'h80000008, 32'hA5A55A5A, 2'd2, 1'b0, 32'h0, 1'b0, 8'h0F, 32'hA5A55A5A);

    // Misaligned / illegal size
    do_req(1'b0, 1'b0, 32'h80000001, 32'h0,        2'd1, 1'b0, 32'h0, 1'b1, 8'h00, 32'h0);
    do_req(1'b0, 1'b1, 32'h80000002, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b1, 8'h00, 32'h0);
    do_req(1'b0, 1'b0, 32'h80000000, 32'h0,        2'd3, 1'b0, 32'h0, 1'b1, 8'h00, 32'h0);

    // LAT=4 store then load back-to-back with req_valid held high
    cur = 1'b1;
    @(negedge clk);
    chk("b2b_ready", {31'b0, req_ready4}, 32'd1);
    req_wen = 1'b1; req_addr = 32'h80000010; req_wdata = 32'hCAFEF00D;
    req_size = 2'd2; req_unsigned = 1'b0; req_valid4 = 1'b1;
    q4.push_back({1'b0, 32'h0});
    rdy_v = '0; wen_v = '0; ren_v = '0; rv_v = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rdy_v[i] = req_ready4; wen_v[i] = mem_wen4;
      ren_v[i] = mem_ren4;   rv_v[i]  = resp_valid4;
      if (i == 4) begin
        req_wen = 1'b0; req_addr = 32'h80000012; req_size = 2'd1; req_unsigned = 1'b1;
        q4.push_back({1'b0, 32'h0000CAFE});
      end
      if (i == 10) req_valid4 = 1'b0;
    end
    chk("b2b_ready_pattern", {20'b0, rdy_v}, 32'h820);
    chk("b2b_wen_pattern",   {20'b0, wen_v}, 32'h001);
    chk("b2b_ren_pattern",   {20'b0, ren_v}, 32'h3C0);
    chk("b2b_resp_pattern",  {20'b0, rv_v},  32'h410);
    chk("b2b_mem_word", mem4[4], 32'hCAFEF00D);

    // Reset in the second BUSY cycle of a LAT=4 load
    @(negedge clk);
    req_wen = 1'b0; req_addr = 32'h80000014; req_size = 2'd2;
    req_unsigned = 1'b0; req_valid4 = 1'b1;
    @(negedge clk);
    req_valid4 = 1'b0;
    @(negedge clk);
    chk("busy2_ren", {31'b0, mem_ren4}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_ctrl", {20'b0, resp_valid4, resp_err4, mem_wen4, mem_ren4, mem_wmask4}, 32'd0);
    chk("rst_mem_addr", mem_addr4, 32'd0);
    chk("rst_wdata", mem_wdata4, 32'd0);
    chk("rst_rdata", resp_rdata4, 32'd0);
    chk("rst_ready", {31'b0, req_ready4}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    do_req(1'b1, 1'b0, 32'h80000014, 32'h0, 2'd2, 1'b0, 32'h55667788, 1'b0, 8'h00, 32'h0);

    repeat (3) @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
